// File: rtl/cam_pkg.sv
// Shared definitions for the parametrised CAM: width helpers and the
// registered search-result record carried by the last pipeline stage.
package cam_pkg;

    // Widest index the CAM ever needs (DEPTH is at most 256).
    localparam int IDX_W_MAX = 8;

    // Ceiling log2 that never returns 0, so a 1-entry table still gets a
    // 1-bit index and all width derivations stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Registered search result. The index is sized for the largest table;
    // the top slices off the bits its DEPTH actually uses.
    typedef struct packed {
        logic                 valid;
        logic                 hit;
        logic [IDX_W_MAX-1:0] index;
        logic                 multi;
    } search_result_t;

endpackage

// File: rtl/cam_priority_encoder.sv
// Lowest-set-bit priority encoder with "any" and "more than one" flags.
// Used on the search match vector and on the inverted valid vector.
module cam_priority_encoder #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] index_o,
    output logic          any_o,
    output logic          multi_o
);

    // Scan from the top down so the last assignment is the lowest set bit.
    always_comb begin
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                index_o = IW'(i);
            end
        end
    end

    assign any_o = |vec_i;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - N'(1)));

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM: DEPTH x WIDTH entries with valid bits, per-entry
// write/invalidate, auto-allocation into the lowest free entry, masked
// search through a two-stage pipeline, and occupancy tracking.
module param_cam
    import cam_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int IDX_W = clog2_min1(DEPTH),
    parameter int CNT_W = clog2_min1(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             read_enable_i,
    input  logic [IDX_W-1:0] read_index_i,
    output logic             read_valid_o,
    output logic [WIDTH-1:0] read_value_o,

    input  logic             write_enable_i,
    input  logic [IDX_W-1:0] write_index_i,
    input  logic [WIDTH-1:0] write_data_i,

    input  logic             invalidate_enable_i,
    input  logic [IDX_W-1:0] invalidate_index_i,

    input  logic             alloc_enable_i,
    output logic             alloc_ack_o,
    output logic             alloc_fail_o,
    output logic [IDX_W-1:0] alloc_index_o,

    input  logic             search_enable_i,
    input  logic [WIDTH-1:0] search_data_i,
    input  logic [WIDTH-1:0] search_mask_i,
    output logic             search_valid_o,
    output logic             search_hit_o,
    output logic [IDX_W-1:0] search_index_o,
    output logic             search_multi_o,

    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [IDX_W:0]   DEPTH_IDX = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // Storage. Every entry is compared in parallel on each search, so the
    // table lives in flops rather than a RAM macro.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Read port registers
    logic             read_valid_q;
    logic             read_valid_d;
    logic [WIDTH-1:0] read_value_q;
    logic [WIDTH-1:0] read_value_d;

    // Alloc status registers
    logic             alloc_ack_q;
    logic             alloc_ack_d;
    logic             alloc_fail_q;
    logic             alloc_fail_d;
    logic [IDX_W-1:0] alloc_index_q;
    logic [IDX_W-1:0] alloc_index_d;

    // Search pipeline: S1 holds the raw match vector, S2 the encoded result
    logic             s1_valid_q;
    logic [DEPTH-1:0] s1_match_q;
    logic [DEPTH-1:0] match_vec;
    search_result_t   res_q;
    search_result_t   res_d;

    // Per-cycle decode
    logic             wr_in_range;
    logic             inv_in_range;
    logic             rd_in_range;
    logic             write_ok;
    logic             inv_ok;
    logic             alloc_ok;
    logic             alloc_rej;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [DEPTH-1:0] entry_we;
    logic [DEPTH-1:0] entry_inv;

    // Encoder outputs
    logic [IDX_W-1:0] free_idx;
    logic             free_any;
    logic             free_multi;
    logic [IDX_W-1:0] m_idx;
    logic             m_any;
    logic             m_multi;

    // Indices beyond DEPTH-1 are silently ignored by every port.
    assign wr_in_range  = ({1'b0, write_index_i}      < DEPTH_IDX);
    assign inv_in_range = ({1'b0, invalidate_index_i} < DEPTH_IDX);
    assign rd_in_range  = ({1'b0, read_index_i}       < DEPTH_IDX);

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);

    assign write_ok  = write_enable_i & wr_in_range;
    assign inv_ok    = invalidate_enable_i & inv_in_range;
    // An explicit write owns the write path this cycle, so alloc yields to it.
    assign alloc_ok  = alloc_enable_i & ~write_enable_i & ~full_o;
    assign alloc_rej = alloc_enable_i & (write_enable_i | full_o);

    // Lowest free slot comes from the pre-edge valid bits, so a same-cycle
    // invalidate never frees a slot for this cycle's alloc.
    cam_priority_encoder #(
        .N  (DEPTH),
        .IW (IDX_W)
    ) u_free_enc (
        .vec_i   (~valid_q),
        .index_o (free_idx),
        .any_o   (free_any),
        .multi_o (free_multi)
    );

    // Per-entry write/invalidate strobes and search comparators.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_we[gi]  = (write_ok && (write_index_i == IDX_W'(gi)))
                            || (alloc_ok && (free_idx == IDX_W'(gi)));
        assign entry_inv[gi] = inv_ok && (invalidate_index_i == IDX_W'(gi));
        // Mask bit 0 is don't-care; an all-zero mask matches any valid entry.
        assign match_vec[gi] = valid_q[gi]
                            && (((mem_q[gi] ^ search_data_i) & search_mask_i) == '0);
    end

    // A write beats a same-cycle invalidate of the same entry.
    assign valid_d = (valid_q & ~entry_inv) | entry_we;

    // Occupancy: count only real valid-bit transitions.
    assign cnt_inc = (write_ok && !valid_q[write_index_i]) || alloc_ok;
    assign cnt_dec = |(entry_inv & valid_q & ~entry_we);

    // Next-state for occupancy, read port and alloc status.
    always_comb begin
        count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

        read_valid_d = 1'b0;
        read_value_d = '0;
        if (read_enable_i && rd_in_range && valid_q[read_index_i]) begin
            read_valid_d = 1'b1;
            read_value_d = mem_q[read_index_i];
        end

        alloc_ack_d   = alloc_ok;
        alloc_fail_d  = alloc_rej;
        alloc_index_d = alloc_ok ? free_idx : alloc_index_q;
    end

    // S2: priority-encode the registered match vector.
    cam_priority_encoder #(
        .N  (DEPTH),
        .IW (IDX_W)
    ) u_match_enc (
        .vec_i   (s1_match_q),
        .index_o (m_idx),
        .any_o   (m_any),
        .multi_o (m_multi)
    );

    // S2 result: everything is forced to zero on a miss or an empty slot.
    always_comb begin
        res_d       = '0;
        res_d.valid = s1_valid_q;
        if (s1_valid_q && m_any) begin
            res_d.hit   = 1'b1;
            res_d.index = IDX_W_MAX'(m_idx);
            res_d.multi = m_multi;
        end
    end

    // Table contents: data is kept on invalidate, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) begin
                    mem_q[i] <= write_data_i;
                end
            end
        end
    end

    // Valid bits, occupancy, read/alloc outputs and search pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            count_q       <= '0;
            read_valid_q  <= 1'b0;
            read_value_q  <= '0;
            alloc_ack_q   <= 1'b0;
            alloc_fail_q  <= 1'b0;
            alloc_index_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_match_q    <= '0;
            res_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            count_q       <= count_d;
            read_valid_q  <= read_valid_d;
            read_value_q  <= read_value_d;
            alloc_ack_q   <= alloc_ack_d;
            alloc_fail_q  <= alloc_fail_d;
            alloc_index_q <= alloc_index_d;
            s1_valid_q    <= search_enable_i;
            s1_match_q    <= search_enable_i ? match_vec : '0;
            res_q         <= res_d;
        end
    end

    assign read_valid_o   = read_valid_q;
    assign read_value_o   = read_value_q;
    assign alloc_ack_o    = alloc_ack_q;
    assign alloc_fail_o   = alloc_fail_q;
    assign alloc_index_o  = alloc_index_q;
    assign search_valid_o = res_q.valid;
    assign search_hit_o   = res_q.hit;
    assign search_index_o = res_q.index[IDX_W-1:0];
    assign search_multi_o = res_q.multi;
    assign count_o        = count_q;

    // Upper result-index bits and the free-slot flags are not needed here
    // (alloc is gated by full_o, which is equivalent to !free_any).
    logic unused_bits;
    assign unused_bits = ^{res_q.index, free_any, free_multi};

endmodule

// File: doc/param_cam.md
Name: param_cam

Overview:
Parametrised content-addressable memory, the successor to the fixed 32x32 CAM. DEPTH entries of WIDTH bits, each entry with a valid bit.
New over the previous generation: per-entry invalidate, masked search with a multi-hit flag, and auto-allocation into the lowest free entry. Also adds occupancy, full and empty status, and a 2-stage registered search pipeline.
Sits between the lookup client and the table-management logic; single clock domain.

Parameters:
DEPTH, 32, number of entries (2..256; need not be a power of two)
WIDTH, 32, bits per entry
IDX_W, $clog2(DEPTH), index width (derived; do not override)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
read_enable_i  in  1  read request
read_index_i  in  IDX_W  read index
read_valid_o  out  1  read result valid (entry existed and was valid)
read_value_o  out  WIDTH  read data
write_enable_i  in  1  write request (sets valid)
write_index_i  in  IDX_W  write index
write_data_i  in  WIDTH  data for write and alloc
invalidate_enable_i  in  1  clear valid bit
invalidate_index_i  in  IDX_W  index to invalidate
alloc_enable_i  in  1  write write_data_i to lowest free entry
alloc_ack_o  out  1  alloc succeeded (pulse)
alloc_fail_o  out  1  alloc rejected (pulse)
alloc_index_o  out  IDX_W  entry used by successful alloc
search_enable_i  in  1  search request, one per cycle accepted
search_data_i  in  WIDTH  search key
search_mask_i  in  WIDTH  1 = compare bit, 0 = don't care
search_valid_o  out  1  search result valid
search_hit_o  out  1  at least one valid entry matched
search_index_o  out  IDX_W  lowest matching index
search_multi_o  out  1  more than one entry matched
count_o  out  CNT_W  number of valid entries
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0

Behaviour:
- Reset (synchronous): all valid bits = 0, all data = 0, pipeline flushed. All outputs 0 except empty_o = 1.
- Reset mid-operation: in-flight search and read results are discarded. Outputs are 0 in the cycle after the reset edge.
- Read: 1-cycle latency, registered.
  - read_valid_o = 1 only if read_enable_i, index < DEPTH and entry valid.
  - Otherwise read_valid_o = 0 and read_value_o = 0.
  - Read sees array state before the same-cycle write (read-before-write).
- Write: commits at the edge; entry data = write_data_i, valid = 1. Ignored if index >= DEPTH.
- Invalidate: valid = 0 at the edge; data retained. Ignored if index >= DEPTH or the entry is already invalid.
- Write and invalidate to the same index in the same cycle: write wins, entry valid with the new data.
- Alloc:
  - Free slot is the lowest index with valid = 0, taken from the pre-edge state.
  - If write_enable_i is also asserted: alloc is dropped, alloc_fail_o = 1 next cycle.
  - Else if full_o: alloc_fail_o = 1 next cycle.
  - Otherwise the entry is written, alloc_ack_o = 1 and alloc_index_o = slot next cycle.
  - A same-cycle invalidate does not create a free slot for that cycle's alloc.
  - alloc_index_o holds its last value when ack = 0.
- Search pipeline, 2-cycle latency, fully pipelined (throughput 1/cycle):
  - S1 registers the match vector: match[i] = valid[i] & (((entry[i] ^ key) & mask) == 0). Compared against array state before the same-cycle write/invalidate/alloc.
  - S2 priority-encodes the match vector. search_valid_o = 1 two cycles after search_enable_i. hit = |match, index = lowest set bit, multi = more than one bit set.
  - On a miss: hit = 0, index = 0, multi = 0. When not valid, all search outputs = 0.
  - An all-zero mask matches every valid entry.
- Occupancy: count_o is registered and updates at the same edge as the array.
  - +1 for a write to an invalid entry; +1 for a successful alloc.
  - -1 for an invalidate of a valid entry.
  - Write and alloc cannot both succeed in one cycle. Invalidate plus a successful alloc in one cycle gives net 0.
  - Never wraps: saturation is structurally impossible and is asserted in verification.
  - full_o and empty_o are derived combinationally from count_o.

Decomposition:
- cam_pkg holds:
  - function clog2_min1 for index width, so DEPTH=1-safe derivations are shared;
  - typedef for the search result struct (valid, hit, index, multi), parametrised via a localparam IDX_W_MAX=8.
- Sub-module cam_priority_encoder #(N): input vector; outputs lowest-set index, any, multi.
- Instantiated twice: on the match vector (S2), and on ~valid for free-slot selection.

Test Plan:
- Reset, then write idx3=0xDEADBEEF, idx7=0xDEADBEEF. Search 0xDEADBEEF, mask all 1s -> 2 cycles later valid=1, hit=1, index=3, multi=1, count_o=2.
- Invalidate idx3, then read idx3 and idx7 -> idx3 read_valid_o=0; idx7 read_valid_o=1, value 0xDEADBEEF; count_o=1.
- Alloc 32 times from empty (DEPTH=32) -> ack with indices 0..31, full_o=1; 33rd alloc -> alloc_fail_o=1, count_o stays 32.
- Write idx5=0x12345678, search key 0x1234FFFF with mask 0xFFFF0000 -> hit=1, index=5. Same search with mask 0xFFFFFFFF -> hit=0, multi=0.
- Search and write to the same key in the same cycle -> that search misses; the search issued the next cycle hits. Back-to-back searches produce results on consecutive cycles.
- Assert rst_i one cycle after search_enable_i -> search_valid_o never asserts; count_o=0, empty_o=1. A write plus invalidate to the same index leaves the entry valid.
